// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment result display: digit count and
// the hex-to-segment table in active-high {g,f,e,d,c,b,a} form.
package seg7_pkg;

    localparam int unsigned DIGITS = 4;

    typedef logic [1:0] digit_idx_t;
    typedef logic [3:0] nibble_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic seg_t hex2seg(input nibble_t n);
        return SEG_TABLE[n];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to active-high segment pattern.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = hex2seg(i_nibble);
    end

endmodule

// File: rtl/seg7_result_display.sv
// 4-digit multiplexed hex display of the SoC result bus. The value is
// snapshotted once per scan frame so a frame never mixes old and new digits.
module seg7_result_display
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLANK_CYC   = 500,
    parameter bit          BLANK_LZ    = 1'b1,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] result,
    input  logic        freeze,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [3:0] AN_POL  = ACTIVE_LOW ? '1 : '0;
    localparam logic [6:0] SEG_POL = ACTIVE_LOW ? '1 : '0;
    localparam logic       DP_OFF  = ACTIVE_LOW;

    logic [CNT_W-1:0] r_cnt;
    digit_idx_t       r_idx;
    logic [15:0]      r_snap;

    logic             w_frame_start;
    logic             w_wrap;
    logic             w_guard;
    logic             w_lz_blank;
    logic             w_lit;
    nibble_t          w_nibble;
    seg_t             w_seg_hi;
    logic [3:0]       w_an_hi;
    seg_t             w_seg_gated;

    assign w_frame_start = (r_cnt == '0) && (r_idx == '0);
    assign w_wrap        = (r_cnt == CNT_W'(REFRESH_DIV - 1));
    assign w_guard       = (32'(r_cnt) < BLANK_CYC);

    always_comb begin
        w_nibble   = r_snap[3:0];
        w_lz_blank = 1'b0;
        case (r_idx)
            2'd0: w_nibble = r_snap[3:0];
            2'd1: begin
                w_nibble   = r_snap[7:4];
                w_lz_blank = (r_snap[15:4] == '0);
            end
            2'd2: begin
                w_nibble   = r_snap[11:8];
                w_lz_blank = (r_snap[15:8] == '0);
            end
            default: begin
                w_nibble   = r_snap[15:12];
                w_lz_blank = (r_snap[15:12] == '0);
            end
        endcase
        if (!BLANK_LZ) begin
            w_lz_blank = 1'b0;
        end
    end

    seg7_decode u_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_hi)
    );

    // Guard window and suppressed leading zeros both turn the whole digit off.
    assign w_lit       = !w_guard && !w_lz_blank;
    assign w_an_hi     = w_lit ? (4'b0001 << r_idx) : '0;
    assign w_seg_gated = w_lit ? w_seg_hi : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_idx  <= '0;
            r_snap <= '0;
            an     <= AN_POL;
            seg    <= SEG_POL;
            dp     <= DP_OFF;
            frame  <= 1'b0;
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            if (w_wrap) begin
                r_idx <= r_idx + 1'b1;
            end
            if (w_frame_start && !freeze) begin
                r_snap <= result;
            end
            frame <= w_frame_start;
            an    <= w_an_hi ^ AN_POL;
            seg   <= w_seg_gated ^ SEG_POL;
            dp    <= DP_OFF;
        end
    end

endmodule
